// File: rtl/fifo_ctrl_4x8.sv
// fifo_ctrl_4x8: pointer, occupancy-flag and pause/continue sequencer for a
// DEPTH-entry buffer memory. Data never passes through this block.
`default_nettype none

module fifo_ctrl_4x8 #(
   parameter int DEPTH     = 4,
   parameter int PTR_W     = 4,
   parameter int CNT_W     = 3,
   parameter int AF_THRESH = 3,
   parameter int AE_THRESH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   output logic             write,
   output logic             read,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             pause,
   output logic [CNT_W-1:0] count,
   output logic             overflow_err,
   output logic             underflow_err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_PAUSE = 1'b1;

   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [0:0]       state_q, state_d;
   logic             push_ok, pop_ok;

   assign full         = (count_q == CNT_W'(DEPTH));
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
   assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

   // Full with a simultaneous pop frees a slot in the same cycle; empty has no bypass.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop);

   // Memory enables are forced low while reset is asserted.
   assign write = push_ok & reset;
   assign read  = pop_ok & reset;

   assign wr_ptr        = PTR_W'(wr_q);
   assign rd_ptr        = PTR_W'(rd_q);
   assign count         = count_q;
   assign overflow_err  = ovf_q;
   assign underflow_err = unf_q;

   always_comb begin
      wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
      rd_d    = pop_ok  ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      ovf_d   = ovf_q | (push & ~push_ok);
      unf_d   = unf_q | (pop & ~pop_ok);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   // Hysteresis: decided on the next occupancy so pause moves with count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (count_d >= CNT_W'(AF_THRESH)) state_d = S_PAUSE;
         S_PAUSE: if (count_d <= CNT_W'(AE_THRESH)) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      pause = (state_q == S_PAUSE);
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl_4x8.sv
// tb_fifo_ctrl_4x8: directed self-checking bench with a behavioural 4x8 memory
// hung off the controller's write/read/pointer outputs.
`default_nettype none

module tb_fifo_ctrl_4x8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] din = 8'h00;
   logic       write, read, full, empty, almost_full, almost_empty;
   logic       pause, overflow_err, underflow_err;
   logic [3:0] wr_ptr, rd_ptr;
   logic [2:0] count;
   logic [7:0] mem [4];
   logic [7:0] dout;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   fifo_ctrl_4x8 dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop),
      .write(write), .read(read), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .pause(pause), .count(count),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always @(posedge clk) if (write) mem[wr_ptr[1:0]] <= din;
   assign dout = mem[rd_ptr[1:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Apply a request, let combinational outputs settle before the edge.
   task automatic drive(input logic p, input logic q, input logic [7:0] d);
      push = p; pop = q; din = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      push = 1'b0; pop = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_low_empty", empty, 1);
      chk("rst_low_count", count, 0);
      #2 reset = 1'b1;
      tick();
      chk("idle_empty", empty, 1);
      chk("idle_ae", almost_empty, 1);
      chk("idle_count", count, 0);
      chk("idle_wr", wr_ptr, 0);
      chk("idle_rd", rd_ptr, 0);
      chk("idle_pause", pause, 0);
      chk("idle_errs", {overflow_err, underflow_err}, 0);
      chk("idle_full", full, 0);

      // Fill A0..A3
      drive(1, 0, 8'hA0);
      chk("fill1_write", write, 1);
      tick();
      chk("fill1_count", count, 1);
      chk("fill1_wr", wr_ptr, 1);
      chk("fill1_ae", almost_empty, 1);
      drive(1, 0, 8'hA1); tick();
      chk("fill2_count", count, 2);
      chk("fill2_ae", almost_empty, 0);
      chk("fill2_pause", pause, 0);
      drive(1, 0, 8'hA2); tick();
      chk("fill3_count", count, 3);
      chk("fill3_af", almost_full, 1);
      chk("fill3_pause", pause, 1);
      chk("fill3_full", full, 0);
      drive(1, 0, 8'hA3); tick();
      chk("fill4_count", count, 4);
      chk("fill4_full", full, 1);
      chk("fill4_wr", wr_ptr, 0);
      chk("fill4_pause", pause, 1);

      // Overflow: push while full
      drive(1, 0, 8'hEE);
      chk("ovf_write", write, 0);
      tick();
      chk("ovf_count", count, 4);
      chk("ovf_err", overflow_err, 1);
      chk("ovf_wr", wr_ptr, 0);

      // Push+pop while full: reads A0, overwrites slot 0 with B0
      drive(1, 1, 8'hB0);
      chk("fpp_write", write, 1);
      chk("fpp_read", read, 1);
      chk("fpp_data", dout, 8'hA0);
      tick();
      chk("fpp_count", count, 4);
      chk("fpp_wr", wr_ptr, 1);
      chk("fpp_rd", rd_ptr, 1);
      chk("fpp_ovf_sticky", overflow_err, 1);

      // Drain with hysteresis
      drive(0, 1, 8'h00);
      chk("d1_data", dout, 8'hA1);
      tick();
      chk("d1_count", count, 3);
      chk("d1_pause", pause, 1);
      drive(0, 1, 8'h00);
      chk("d2_data", dout, 8'hA2);
      tick();
      chk("d2_count", count, 2);
      chk("d2_pause", pause, 1);
      drive(0, 1, 8'h00);
      chk("d3_data", dout, 8'hA3);
      tick();
      chk("d3_count", count, 1);
      chk("d3_pause", pause, 0);
      chk("d3_rd", rd_ptr, 0);
      drive(0, 1, 8'h00);
      chk("d4_data", dout, 8'hB0);
      tick();
      chk("d4_count", count, 0);
      chk("d4_empty", empty, 1);
      chk("d4_rd", rd_ptr, 1);
      chk("d4_unf", underflow_err, 0);

      // Underflow
      drive(0, 1, 8'h00);
      chk("unf_read", read, 0);
      tick();
      chk("unf_err", underflow_err, 1);
      chk("unf_count", count, 0);
      chk("unf_rd", rd_ptr, 1);

      // Push+pop while empty
      drive(1, 1, 8'hC1);
      chk("epp_write", write, 1);
      chk("epp_read", read, 0);
      tick();
      chk("epp_count", count, 1);
      chk("epp_wr", wr_ptr, 2);
      chk("epp_rd", rd_ptr, 1);

      drive(1, 0, 8'hC2); tick();
      chk("pre_rst_count", count, 2);
      chk("pre_rst_pause", pause, 0);

      // Async reset between edges, push held high
      push = 1'b1; din = 8'hD0;
      #1 reset = 1'b0;
      #1;
      chk("arst_count", count, 0);
      chk("arst_wr", wr_ptr, 0);
      chk("arst_rd", rd_ptr, 0);
      chk("arst_empty", empty, 1);
      chk("arst_write", write, 0);
      chk("arst_errs", {overflow_err, underflow_err}, 0);
      chk("arst_pause", pause, 0);
      #1 reset = 1'b1;
      tick();
      chk("resume_count", count, 1);
      chk("resume_wr", wr_ptr, 1);
      chk("resume_rd", rd_ptr, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/fifo_ctrl_4x8.md
Name: fifo_ctrl_4x8

Overview:
Pointer, flag and flow-control sequencer for the 4-entry x 8-bit buffer memory of the PCIe switching datapath. It accepts push/pop requests from the upstream and downstream logic and drives the memory's write, read, wr_ptr and rd_ptr inputs. It tracks occupancy, raises full/empty and threshold flags, and runs a hysteresis pause/continue FSM that the upstream arbiter uses as back-pressure. Data does not pass through this block: the memory's data_in and data_out connect directly to the datapath.

Parameters:
DEPTH, 4, number of memory entries; must be a power of 2 and at least 2.
PTR_W, 4, width of the pointer ports; matches the memory's pointer width. Only the low log2(DEPTH) bits count; upper bits are driven 0.
CNT_W, 3, occupancy counter width; equals log2(DEPTH)+1.
AF_THRESH, 3, almost-full / pause threshold; must satisfy AE_THRESH < AF_THRESH <= DEPTH.
AE_THRESH, 1, almost-empty / continue threshold.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
push  input  1  upstream requests a write this cycle.
pop  input  1  downstream requests a read this cycle.
write  output  1  memory write enable, combinational: push_ok.
read  output  1  memory read enable, combinational: pop_ok.
wr_ptr  output  PTR_W  memory write address, registered.
rd_ptr  output  PTR_W  memory read address, registered.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
pause  output  1  back-pressure to upstream; registered FSM output.
count  output  CNT_W  current occupancy, registered.
overflow_err  output  1  sticky flag: a push was rejected.
underflow_err  output  1  sticky flag: a pop was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0, FSM=RUN, pause=0, overflow_err=0, underflow_err=0.
  - Flags follow from count=0: empty=1, full=0, almost_empty=1, almost_full=0.
  - write and read are 0 while reset is low.
- Accept rules:
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop).
  - When full, a simultaneous push and pop are both accepted. The memory read returns the old entry combinationally, and the write lands at the clock edge.
  - When empty, a simultaneous push and pop: push is accepted, pop is rejected. There is no bypass path.
- Read latency: data_out is valid in the same cycle that read=1. rd_ptr advances at the following edge.
- Write: data_in is captured at the edge where write=1. The entry is readable from the next cycle.
- Pointer update at each edge:
  - wr_ptr increments by 1 when push_ok; rd_ptr increments by 1 when pop_ok.
  - Both wrap from DEPTH-1 to 0, i.e. modulo DEPTH. Bits at or above log2(DEPTH) stay 0.
- Count update at each edge: count_next = count + push_ok - pop_ok. It never exceeds DEPTH and never goes below 0.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- Errors:
  - overflow_err is set on any cycle with push & ~push_ok.
  - underflow_err is set on any cycle with pop & ~pop_ok.
  - Both are sticky until reset. A rejected request leaves the pointers and count unchanged.
- FSM, evaluated on count_next and registered:
  - RUN (pause=0): go to PAUSE when count_next >= AF_THRESH.
  - PAUSE (pause=1): go to RUN when count_next <= AE_THRESH; otherwise stay in PAUSE.
  - pause updates at the same edge as count. Between the thresholds, pause holds its previous state (hysteresis).
  - pause is advisory only: pushes during PAUSE are still accepted if not full.
- Reset mid-operation: all state clears immediately. In-flight requests are discarded. Stale memory contents are unreachable because empty=1.

Test Plan:
- Reset then idle: after reset is released -> empty=1, almost_empty=1, count=0, wr_ptr=rd_ptr=0, pause=0, no errors.
- Fill: 4 consecutive pushes -> count goes 1,2,3,4; almost_full=1 from count 3; pause=1 from the edge where count reaches 3; full=1 at count 4; wr_ptr=0 after wrapping.
- Overflow: push while full with pop=0 -> write=0, count stays 4, overflow_err=1 and stays 1; a later push+pop while full -> write=read=1, count stays 4, wr_ptr and rd_ptr both +1.
- Drain with hysteresis: from full, pop once per cycle -> pause stays 1 at count 3 and 2, drops at the edge to count 1; empty=1 at count 0; data order matches the push order (e.g. pushing A0,A1,A2,A3 pops A0..A3).
- Underflow and empty corner: pop when empty -> read=0, underflow_err=1; push+pop when empty -> write=1, read=0, count=1.
- Async reset mid-stream: with count=2 and pause=0, drive reset low between clock edges -> all outputs reach their reset values without waiting for a clock edge; normal operation resumes on the first edge after release.
